// File: rtl/pl_gen_burst.sv
// ---------------------------------------------------------------------------
// pl_gen_burst
//
// Periodic burst payload generator feeding a channel coder.
//
// A free-running period timer counts enabled ticks. At every period start
// (timer at zero on an enabled edge) an idle generator with gen_en set opens a
// burst of BURST words. The words are offered one at a time through pl_rdy/q.
// The coder accepts a word on any enabled edge where cd_busy is low.
//
// Word values follow a pattern chosen at burst start:
//   inc, dec, Galois LFSR, or constant.
// The pattern state lives in q itself, so the sequence carries on across
// bursts and across pattern changes. Only reset reloads q.
//
// A period start that arrives while a burst is still being offered is not
// queued. That burst is dropped, and ovr_cnt records the loss (saturating).
//
// Parameters
//   DW          payload word width (>= 2)
//   GEN_PERIOD  timer terminal count; one period = GEN_PERIOD+1 enabled ticks
//   BURST       words per burst (1..255)
//   SEED        reset value of q; LFSR escape value when q is all-zero
//   LFSR_TAPS   Galois LFSR tap mask
//
// Ports
//   clk      in   system clock
//   n_rst    in   asynchronous active-low reset
//   clk_en   in   tick enable; nothing changes state while low
//   gen_en   in   permits new bursts (a running burst always completes)
//   mode     in   pattern select: 0 inc, 1 dec, 2 LFSR, 3 constant
//   cd_busy  in   coder busy; blocks the transfer
//   pl_rdy   out  q holds an offered word
//   q        out  payload word
//   pl_last  out  offered word is the last of its burst
//   ovr_cnt  out  saturating count of missed period starts
// ---------------------------------------------------------------------------
module pl_gen_burst #(
  parameter int            DW         = 8,
  parameter int            GEN_PERIOD = 31,
  parameter int            BURST      = 1,
  parameter logic [DW-1:0] SEED       = DW'(8'h55),
  parameter logic [DW-1:0] LFSR_TAPS  = DW'(8'hB8)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clk_en,
  input  logic          gen_en,
  input  logic [1:0]    mode,
  input  logic          cd_busy,
  output logic          pl_rdy,
  output logic [DW-1:0] q,
  output logic          pl_last,
  output logic [7:0]    ovr_cnt
);

  localparam int            TW       = $clog2(GEN_PERIOD + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(GEN_PERIOD);
  localparam logic [7:0]    BURST_W  = 8'(BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] ticks;
  logic [7:0]    words_left;
  logic [7:0]    words_left_nxt;
  logic [1:0]    mode_r;
  logic [1:0]    mode_r_nxt;
  logic [DW-1:0] q_nxt;
  logic          pl_last_nxt;
  logic [7:0]    ovr_cnt_nxt;
  logic          period_start;
  logic          xfer;

  // Next pattern word, modulo 2^DW.
  // An all-zero LFSR state would lock up, so it escapes back to SEED.
  function automatic logic [DW-1:0] next_pattern(input logic [1:0]    m,
                                                 input logic [DW-1:0] cur);
    logic [DW-1:0] r;
    r = cur;
    case (m)
      2'd0:    r = cur + DW'(1);
      2'd1:    r = cur - DW'(1);
      2'd2:    r = (cur == '0) ? SEED
                               : ((cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0));
      default: r = cur;
    endcase
    return r;
  endfunction

  // Overrun counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Every state change below is qualified by clk_en:
  //   - period_start and xfer both include it;
  //   - the timer only advances under it.
  assign period_start = clk_en && (ticks == '0);
  assign xfer         = clk_en && (state == OFFER) && !cd_busy;

  // The state register is the offer flag itself.
  assign pl_rdy = (state == OFFER);

  // Period timer: runs regardless of FSM state and gen_en.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ticks <= '0;
    end else if (clk_en) begin
      ticks <= (ticks == TICK_MAX) ? '0 : ticks + TW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      words_left <= 8'd0;
      mode_r     <= 2'd0;
      q          <= SEED;
      pl_last    <= 1'b0;
      ovr_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      words_left <= words_left_nxt;
      mode_r     <= mode_r_nxt;
      q          <= q_nxt;
      pl_last    <= pl_last_nxt;
      ovr_cnt    <= ovr_cnt_nxt;
    end
  end

  // Next-state and datapath update.
  // pl_last is computed one step ahead, so that it is registered alongside q.
  always_comb begin
    state_nxt      = state;
    words_left_nxt = words_left;
    mode_r_nxt     = mode_r;
    q_nxt          = q;
    pl_last_nxt    = pl_last;
    ovr_cnt_nxt    = ovr_cnt;

    case (state)
      IDLE: begin
        if (period_start && gen_en) begin
          state_nxt      = OFFER;
          mode_r_nxt     = mode;
          words_left_nxt = BURST_W;
          pl_last_nxt    = (BURST_W == 8'd1);
        end
      end

      OFFER: begin
        // A new period while still offering loses that period's burst.
        // This holds even when the current burst finishes on this edge:
        // the FSM still drops to IDLE and does not restart.
        if (period_start) begin
          ovr_cnt_nxt = sat_inc(ovr_cnt);
        end
        if (xfer) begin
          q_nxt          = next_pattern(mode_r, q);
          words_left_nxt = words_left - 8'd1;
          pl_last_nxt    = (words_left == 8'd2);
          if (words_left == 8'd1) begin
            state_nxt   = IDLE;
            pl_last_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pl_gen_burst.sv
// ---------------------------------------------------------------------------
// tb_pl_gen_burst
//
// Bench for pl_gen_burst. It uses two instances:
//   u_b1  BURST = 1
//   u_b4  BURST = 4
//
// Expected words ({last, q}) are pushed to a per-instance queue before each
// burst is allowed to start. A negedge monitor predicts each transfer from
// pl_rdy, clk_en and cd_busy, then pops the queue and compares the word.
//
// The monitor also checks that:
//   - q never changes without a transfer;
//   - pl_rdy rises exactly GEN_PERIOD+1 enabled ticks apart.
// ---------------------------------------------------------------------------
module tb_pl_gen_burst;

  logic       clk;
  logic       n_rst1, n_rst4;
  logic       clk_en;
  logic       gen_en1, gen_en4;
  logic [1:0] mode;
  logic       cd_busy;
  logic       pl_rdy1, pl_rdy4;
  logic [7:0] q1, q4;
  logic       pl_last1, pl_last4;
  logic [7:0] ovr1, ovr4;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] exp1[$];
  logic [8:0] exp4[$];
  int         xfer1 = 0, xfer4 = 0;
  logic       pend1 = 0, pend4 = 0;
  logic       skip1 = 1, skip4 = 1;
  logic [7:0] prevq1 = 8'h55, prevq4 = 8'h55;
  logic       prevrdy1 = 0, prevrdy4 = 0;
  int         en_cnt = 0;
  int         rise_en1 = 0, rise_en4 = 0;
  bit         rise_ok1 = 0, rise_ok4 = 0;
  logic [7:0] rise_ovr1 = 0, rise_ovr4 = 0;
  bit         per_chk1 = 0, per_chk4 = 0;
  int         hi1 = 0;
  logic [8:0] e1, e4;

  pl_gen_burst #(.BURST(1)) u_b1 (
    .clk(clk), .n_rst(n_rst1), .clk_en(clk_en), .gen_en(gen_en1),
    .mode(mode), .cd_busy(cd_busy), .pl_rdy(pl_rdy1), .q(q1),
    .pl_last(pl_last1), .ovr_cnt(ovr1)
  );

  pl_gen_burst #(.BURST(4)) u_b4 (
    .clk(clk), .n_rst(n_rst4), .clk_en(clk_en), .gen_en(gen_en4),
    .mode(mode), .cd_busy(cd_busy), .pl_rdy(pl_rdy4), .q(q4),
    .pl_last(pl_last4), .ovr_cnt(ovr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic rst_check(input string tag, input logic rdy,
                           input logic [7:0] qq, input logic last,
                           input logic [7:0] ovr);
    check({tag, "_rdy"}, 32'(rdy), 32'(0));
    check({tag, "_q"},   32'(qq),  32'(8'h55));
    check({tag, "_last"}, 32'(last), 32'(0));
    check({tag, "_ovr"}, 32'(ovr), 32'(0));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits until the instance's transfer count reaches target.
  // Returns 1 time unit after the transfer edge.
  task automatic wait_xfer(input int which, input int target, input int limit,
                           input string tag);
    int k;
    k = 0;
    while (((which == 1) ? xfer1 : xfer4) < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({tag, "_timeout"}, 32'(((which == 1) ? xfer1 : xfer4) >= target),
          32'(1));
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    // ---- instance BURST=1
    if (!n_rst1) begin
      skip1 = 1; pend1 = 0; prevrdy1 = 0; rise_ok1 = 0;
    end else begin
      if (!skip1 && !pend1) check("b1_q_hold", 32'(q1), 32'(prevq1));
      skip1 = 0;
      if (per_chk1 && pl_rdy1 && !prevrdy1) begin
        if (rise_ok1 && ovr1 == rise_ovr1)
          check("b1_period", 32'(en_cnt - rise_en1), 32'(32));
        rise_ok1 = 1; rise_en1 = en_cnt; rise_ovr1 = ovr1;
      end
      if (per_chk1 && pl_rdy1) hi1++;
      prevrdy1 = pl_rdy1;
      pend1 = pl_rdy1 && clk_en && !cd_busy;
      if (pend1) begin
        xfer1++;
        if (exp1.size() == 0) check("b1_unexpected_xfer", 32'(1), 32'(0));
        else begin
          e1 = exp1.pop_front();
          check("b1_word", 32'(q1), 32'(e1[7:0]));
          check("b1_last", 32'(pl_last1), 32'(e1[8]));
        end
      end
    end
    prevq1 = q1;

    // ---- instance BURST=4
    if (!n_rst4) begin
      skip4 = 1; pend4 = 0; prevrdy4 = 0; rise_ok4 = 0;
    end else begin
      if (!skip4 && !pend4) check("b4_q_hold", 32'(q4), 32'(prevq4));
      skip4 = 0;
      if (per_chk4 && pl_rdy4 && !prevrdy4) begin
        if (rise_ok4 && ovr4 == rise_ovr4)
          check("b4_period", 32'(en_cnt - rise_en4), 32'(32));
        rise_ok4 = 1; rise_en4 = en_cnt; rise_ovr4 = ovr4;
      end
      prevrdy4 = pl_rdy4;
      pend4 = pl_rdy4 && clk_en && !cd_busy;
      if (pend4) begin
        xfer4++;
        if (exp4.size() == 0) check("b4_unexpected_xfer", 32'(1), 32'(0));
        else begin
          e4 = exp4.pop_front();
          check("b4_word", 32'(q4), 32'(e4[7:0]));
          check("b4_last", 32'(pl_last4), 32'(e4[8]));
        end
      end
    end
    prevq4 = q4;

    // Count the enabled edge that follows this sample.
    if (clk_en) en_cnt++;
  end

  initial begin
    int base;
    int k;
    n_rst1 = 0; n_rst4 = 0; clk_en = 0; gen_en1 = 0; gen_en4 = 0;
    mode = 2'd0; cd_busy = 0;

    // Reset held, then released with clk_en low.
    step(3);
    rst_check("rst_b1", pl_rdy1, q1, pl_last1, ovr1);
    rst_check("rst_b4", pl_rdy4, q4, pl_last4, ovr4);
    n_rst1 = 1; n_rst4 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_check("idle_b1", pl_rdy1, q1, pl_last1, ovr1);
      rst_check("idle_b4", pl_rdy4, q4, pl_last4, ovr4);
    end
    step(1);

    // Increment, BURST=1.
    mode = 2'd0; cd_busy = 0; clk_en = 1;
    exp1.push_back({1'b1, 8'h55});
    exp1.push_back({1'b1, 8'h56});
    exp1.push_back({1'b1, 8'h57});
    hi1 = 0; per_chk1 = 1; gen_en1 = 1;
    wait_xfer(1, 3, 200, "inc");
    gen_en1 = 0;
    step(2);
    per_chk1 = 0;
    check("inc_rdy_cycles", 32'(hi1), 32'(3));

    // Dec burst; mode changes to LFSR mid-burst, so LFSR applies next burst.
    mode = 2'd1;
    exp4.push_back({1'b0, 8'h55});
    exp4.push_back({1'b0, 8'h54});
    exp4.push_back({1'b0, 8'h53});
    exp4.push_back({1'b1, 8'h52});
    gen_en4 = 1;
    wait_xfer(4, 2, 100, "dec_half");
    mode = 2'd2;
    wait_xfer(4, 4, 100, "dec");
    exp4.push_back({1'b0, 8'h51});
    exp4.push_back({1'b0, 8'h90});
    exp4.push_back({1'b0, 8'h48});
    exp4.push_back({1'b1, 8'h24});
    wait_xfer(4, 8, 100, "lfsr_cont");
    gen_en4 = 0;
    check("declfsr_ovr", 32'(ovr4), 32'(0));

    // Reset, then LFSR from the seed.
    n_rst4 = 0;
    step(2);
    rst_check("rst2_b4", pl_rdy4, q4, pl_last4, ovr4);
    n_rst4 = 1;
    exp4.push_back({1'b0, 8'h55});
    exp4.push_back({1'b0, 8'h92});
    exp4.push_back({1'b0, 8'h49});
    exp4.push_back({1'b1, 8'h9C});
    base = xfer4;
    gen_en4 = 1;
    wait_xfer(4, base + 4, 100, "lfsr_seed");
    gen_en4 = 0;

    // Overrun on BURST=1: coder busy for 70 cycles.
    n_rst1 = 0;
    step(2);
    n_rst1 = 1; cd_busy = 1; mode = 2'd0; gen_en1 = 1;
    k = 0;
    while (!pl_rdy1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ovr_start_timeout", 32'(pl_rdy1), 32'(1));
    step(1);
    gen_en1 = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        check("ovr_hold_rdy", 32'(pl_rdy1), 32'(1));
        check("ovr_hold_q", 32'(q1), 32'(8'h55));
      end
    end
    step(1);
    check("ovr_cnt_release", 32'(ovr1), 32'(2));
    exp1.push_back({1'b1, 8'h55});
    cd_busy = 0;
    @(negedge clk);
    @(negedge clk);
    check("ovr_done_rdy", 32'(pl_rdy1), 32'(0));
    check("ovr_done_q", 32'(q1), 32'(8'h56));

    // Overrun counter saturation.
    step(1);
    n_rst1 = 0;
    step(2);
    n_rst1 = 1; cd_busy = 1; gen_en1 = 1;
    step(1);
    gen_en1 = 0;
    step(32 * 258);
    check("ovr_saturate", 32'(ovr1), 32'(255));
    check("ovr_sat_rdy", 32'(pl_rdy1), 32'(1));
    exp1.push_back({1'b1, 8'h55});
    cd_busy = 0;
    step(3);
    check("ovr_sat_done", 32'(pl_rdy1), 32'(0));

    // Throttling and gating, BURST=4, incrementing words.
    n_rst4 = 0;
    step(2);
    n_rst4 = 1; mode = 2'd0;
    for (int i = 0; i < 12; i++)
      exp4.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 8'(8'h55 + i)});
    base = xfer4;
    per_chk4 = 1; gen_en4 = 1;
    k = 0;
    while (xfer4 < base + 12 && k < 1500) begin
      @(posedge clk);
      #1;
      clk_en  = ($urandom_range(0, 2) != 0);
      cd_busy = ($urandom_range(0, 3) == 0);
      k++;
    end
    gen_en4 = 0; clk_en = 1; cd_busy = 0;
    check("thr_timeout", 32'(xfer4 - base), 32'(12));
    step(2);
    per_chk4 = 0;
    check("thr_ovr", 32'(ovr4), 32'(0));
    check("thr_q_end", 32'(q4), 32'(8'h61));

    // Reset in the middle of a burst.
    n_rst4 = 0;
    step(2);
    n_rst4 = 1; mode = 2'd0;
    exp4.push_back({1'b0, 8'h55});
    exp4.push_back({1'b0, 8'h56});
    base = xfer4;
    gen_en4 = 1;
    wait_xfer(4, base + 2, 100, "mid_half");
    n_rst4 = 0; cd_busy = 1;
    #1;
    rst_check("mid_rst", pl_rdy4, q4, pl_last4, ovr4);
    check("mid_queue_empty", 32'(exp4.size()), 32'(0));
    step(2);
    exp4.push_back({1'b0, 8'h55});
    exp4.push_back({1'b0, 8'h56});
    exp4.push_back({1'b0, 8'h57});
    exp4.push_back({1'b1, 8'h58});
    base = xfer4;
    cd_busy = 0; n_rst4 = 1;
    wait_xfer(4, base + 4, 100, "mid_after");
    gen_en4 = 0;
    step(3);
    check("mid_after_rdy", 32'(pl_rdy4), 32'(0));

    check("end_q1_empty", 32'(exp1.size()), 32'(0));
    check("end_q4_empty", 32'(exp4.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
